// File: rtl/set_cond_unit.sv
// set_cond_unit: pipelined DLX set-on-condition unit.
// Compares A and B (signed or unsigned) under COND and emits a
// zero-extended 0/1 result through STAGES register stages.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   VALID_IN   operands and condition valid this cycle
//   STALL      freeze every stage, do not capture the input
//   FLUSH      empty the pipeline and drop the current input
//   A, B       WIDTH-bit operands
//   COND       relation code (EQ NE LT GT LE GE FALSE TRUE)
//   SIGNED     1 = two's-complement compare, 0 = unsigned
//   RESULT     {WIDTH-1 zeros, FLAG}
//   FLAG       condition outcome
//   VALID_OUT  RESULT/FLAG carry a completed operation
module set_cond_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VALID_IN,
    input  logic             STALL,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       COND,
    input  logic             SIGNED,
    output logic [WIDTH-1:0] RESULT,
    output logic             FLAG,
    output logic             VALID_OUT
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] C_EQ = 3'b000;
    localparam logic [2:0] C_NE = 3'b001;
    localparam logic [2:0] C_LT = 3'b010;
    localparam logic [2:0] C_GT = 3'b011;
    localparam logic [2:0] C_LE = 3'b100;
    localparam logic [2:0] C_GE = 3'b101;
    localparam logic [2:0] C_F  = 3'b110;
    localparam logic [2:0] C_T  = 3'b111;

    function automatic logic decode(
        input logic [2:0] c,
        input logic       eq,
        input logic       lt
    );
        logic r;
        r = 1'b0;
        unique case (c)
            C_EQ: r = eq;
            C_NE: r = !eq;
            C_LT: r = lt;
            C_GT: r = !lt && !eq;
            C_LE: r = lt || eq;
            C_GE: r = !lt;
            C_F:  r = 1'b0;
            C_T:  r = 1'b1;
        endcase
        return r;
    endfunction

    // Inverting the sign bit for signed compares maps two's-complement
    // order onto unsigned order, so one magnitude comparator serves both.
    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic             eq_in;
    logic             lt_in;

    always_comb begin
        a_cmp = {A[MSB] ^ SIGNED, A[MSB-1:0]};
        b_cmp = {B[MSB] ^ SIGNED, B[MSB-1:0]};
        eq_in = (A == B);
        lt_in = (a_cmp < b_cmp);
    end

    logic out_flag;
    logic out_vld;

    if (STAGES == 1) begin : g_single
        // Single stage: decode ahead of the only register.
        logic flag_q;
        logic flag_d;
        logic vld_q;
        logic vld_d;

        always_comb begin
            vld_d  = VALID_IN;
            flag_d = VALID_IN && decode(COND, eq_in, lt_in);
        end

        always_ff @(posedge CLK) begin
            if (RST || FLUSH) begin
                flag_q <= 1'b0;
                vld_q  <= 1'b0;
            end else if (!STALL) begin
                flag_q <= flag_d;
                vld_q  <= vld_d;
            end
        end

        assign out_flag = flag_q;
        assign out_vld  = vld_q;
    end else begin : g_multi
        // Stage 1 holds the raw flags; decode sits in front of stage 2.
        logic       s1_vld_q;
        logic       s1_vld_d;
        logic       s1_eq_q;
        logic       s1_eq_d;
        logic       s1_lt_q;
        logic       s1_lt_d;
        logic [2:0] s1_cond_q;
        logic [2:0] s1_cond_d;

        // Stages 2..STAGES: outcome/valid delay chain.
        logic [STAGES-2:0] ch_vld_q;
        logic [STAGES-2:0] ch_vld_d;
        logic [STAGES-2:0] ch_flag_q;
        logic [STAGES-2:0] ch_flag_d;

        // Bubbles carry all-zero flags so the decoded outcome is 0.
        always_comb begin
            s1_vld_d  = VALID_IN;
            s1_eq_d   = VALID_IN && eq_in;
            s1_lt_d   = VALID_IN && lt_in;
            s1_cond_d = VALID_IN ? COND : 3'b000;
        end

        always_comb begin
            ch_vld_d     = '0;
            ch_flag_d    = '0;
            ch_vld_d[0]  = s1_vld_q;
            ch_flag_d[0] = s1_vld_q &&
                           decode(s1_cond_q, s1_eq_q, s1_lt_q);
            for (int i = 1; i < STAGES - 1; i++) begin
                ch_vld_d[i]  = ch_vld_q[i-1];
                ch_flag_d[i] = ch_flag_q[i-1];
            end
        end

        always_ff @(posedge CLK) begin
            if (RST || FLUSH) begin
                s1_vld_q  <= 1'b0;
                s1_eq_q   <= 1'b0;
                s1_lt_q   <= 1'b0;
                s1_cond_q <= 3'b000;
                ch_vld_q  <= '0;
                ch_flag_q <= '0;
            end else if (!STALL) begin
                s1_vld_q  <= s1_vld_d;
                s1_eq_q   <= s1_eq_d;
                s1_lt_q   <= s1_lt_d;
                s1_cond_q <= s1_cond_d;
                ch_vld_q  <= ch_vld_d;
                ch_flag_q <= ch_flag_d;
            end
        end

        assign out_flag = ch_flag_q[STAGES-2];
        assign out_vld  = ch_vld_q[STAGES-2];
    end

    assign FLAG      = out_flag;
    assign VALID_OUT = out_vld;
    assign RESULT    = {{(WIDTH-1){1'b0}}, out_flag};

endmodule

// File: tb/tb_set_cond_unit.sv
// tb_set_cond_unit: self-checking bench for set_cond_unit.
// Three instances (32b/2, 8b/1, 8b/4) checked against a reference model.
module tb_set_cond_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  cond = 3'b000;
    logic        sgn = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;

    logic [31:0] r0;
    logic        f0, v0;
    logic [7:0]  r1, r2;
    logic        f1, v1, f2, v2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    set_cond_unit #(.WIDTH(32), .STAGES(2)) u0 (
        .CLK(clk), .RST(rst), .VALID_IN(vin), .STALL(stall),
        .FLUSH(flush), .A(a32), .B(b32), .COND(cond), .SIGNED(sgn),
        .RESULT(r0), .FLAG(f0), .VALID_OUT(v0));

    set_cond_unit #(.WIDTH(8), .STAGES(1)) u1 (
        .CLK(clk), .RST(rst), .VALID_IN(vin), .STALL(stall),
        .FLUSH(flush), .A(a8), .B(b8), .COND(cond), .SIGNED(sgn),
        .RESULT(r1), .FLAG(f1), .VALID_OUT(v1));

    set_cond_unit #(.WIDTH(8), .STAGES(4)) u2 (
        .CLK(clk), .RST(rst), .VALID_IN(vin), .STALL(stall),
        .FLUSH(flush), .A(a8), .B(b8), .COND(cond), .SIGNED(sgn),
        .RESULT(r2), .FLAG(f2), .VALID_OUT(v2));

    // Model: per instance, the list of (valid, flag) items in flight,
    // oldest at the output end.
    int dep [3] = '{2, 1, 4};
    bit m_v [3][4];
    bit m_f [3][4];

    function automatic bit ref_flag(input logic [2:0] c,
                                    input longint x, input longint y);
        case (c)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd2: return x < y;
            3'd3: return x > y;
            3'd4: return x <= y;
            3'd5: return x >= y;
            3'd6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic longint ext32(input logic [31:0] v, input bit s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic longint ext8(input logic [7:0] v, input bit s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    task automatic model_edge();
        bit nf [3];
        nf[0] = ref_flag(cond, ext32(a32, sgn), ext32(b32, sgn));
        nf[1] = ref_flag(cond, ext8(a8, sgn), ext8(b8, sgn));
        nf[2] = nf[1];
        for (int k = 0; k < 3; k++) begin
            if (rst || flush) begin
                for (int i = 0; i < 4; i++) begin
                    m_v[k][i] = 0;
                    m_f[k][i] = 0;
                end
            end else if (!stall) begin
                for (int i = dep[k] - 1; i > 0; i--) begin
                    m_v[k][i] = m_v[k][i-1];
                    m_f[k][i] = m_f[k][i-1];
                end
                m_v[k][0] = vin;
                m_f[k][0] = vin && nf[k];
            end
        end
    endtask

    function automatic logic [33:0] obs(input int k);
        case (k)
            0: return {v0, f0, r0};
            1: return {v1, f1, 24'b0, r1};
            default: return {v2, f2, 24'b0, r2};
        endcase
    endfunction

    function automatic logic [33:0] expv(input int k);
        bit v, f;
        v = m_v[k][dep[k]-1];
        f = m_f[k][dep[k]-1];
        return {v, f, 31'b0, f};
    endfunction

    task automatic step(input bit r, input bit fl, input bit st,
                        input bit v, input logic [2:0] c, input bit s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] sa, input logic [7:0] sb);
        @(negedge clk);
        rst = r; flush = fl; stall = st; vin = v;
        cond = c; sgn = s; a32 = a; b32 = b; a8 = sa; b8 = sb;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            step(j < 2, 0, 0, j < 2, 3'd7, 0, 1, 1, 1, 1);
            total++;
            if ({v0, f0, r0} !== 34'd0) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=0", j,
                         {v0, f0, r0});
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL reset_model k=%0d got=%h want=%h",
                             k, obs(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_relations();
        bit seq [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
        for (int j = 0; j < 9; j++) begin
            step(0, 0, 0, j < 8, 3'(j), 0, 5, 7, 5, 7);
            if (j >= 1) begin
                total++;
                if ({v0, f0, r0} !== {1'b1, seq[j-1], 31'b0, seq[j-1]}) begin
                    bad++;
                    $display("FAIL relation cond=%0d got=%h want_flag=%0d",
                             j - 1, {v0, f0, r0}, seq[j-1]);
                end
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL rel_model k=%0d got=%h want=%h",
                             k, obs(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_signed();
        bit want [3] = '{1, 0, 1};
        step(0, 0, 0, 1, 3'd2, 1, 32'hFFFF_FFFF, 32'h1, 8'hFF, 8'h01);
        step(0, 0, 0, 1, 3'd2, 0, 32'hFFFF_FFFF, 32'h1, 8'hFF, 8'h01);
        for (int j = 0; j < 3; j++) begin
            if (j == 0)
                total++;
            else
                total++;
            if ({v0, f0} !== {1'b1, want[j]}) begin
                bad++;
                $display("FAIL signed op=%0d got=%b%b want=1%0d",
                         j, v0, f0, want[j]);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL sgn_model k=%0d got=%h want=%h",
                             k, obs(k), expv(k));
                end
            end
            if (j == 0)
                step(0, 0, 0, 1, 3'd3, 0, 32'h8000_0000, 32'h7FFF_FFFF,
                     8'h80, 8'h7F);
            else
                step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_stall();
        bit wv [6] = '{1, 1, 1, 1, 1, 0};
        bit wf [6] = '{1, 1, 1, 1, 0, 0};
        step(0, 0, 0, 1, 3'd0, 0, 3, 3, 3, 3);
        for (int j = 0; j < 6; j++) begin
            if (j == 0)
                step(0, 0, 0, 1, 3'd1, 0, 3, 3, 3, 3);
            else
                step(0, 0, j <= 3, 0, 3'd0, 0, 0, 0, 0, 0);
            total++;
            if ({v0, f0} !== {wv[j], wf[j]}) begin
                bad++;
                $display("FAIL stall cyc=%0d got=%b%b want=%0d%0d",
                         j, v0, f0, wv[j], wf[j]);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL stall_model k=%0d got=%h want=%h",
                             k, obs(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_flush();
        step(0, 0, 0, 1, 3'd7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3'd7, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 3'd7, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            if (j == 1)
                step(0, 0, 0, 1, 3'd7, 0, 0, 0, 0, 0);
            else if (j > 0)
                step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL flush_model k=%0d got=%h want=%h",
                             k, obs(k), expv(k));
                end
            end
            total++;
            if ({v0, r0} !== ((j == 2) ? {1'b1, 32'h1} : 33'd0)) begin
                bad++;
                $display("FAIL flush cyc=%0d got=%h want_valid=%0d",
                         j, {v0, r0}, j == 2);
            end
        end
    endtask

    task automatic test_depth();
        bit w1v [4] = '{1, 1, 0, 0};
        bit w1f [4] = '{0, 1, 0, 0};
        bit w4v [6] = '{0, 0, 0, 1, 1, 0};
        bit w4f [6] = '{0, 0, 0, 0, 1, 0};
        for (int j = 0; j < 4; j++)
            step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 6; j++) begin
            step(0, 0, 0, j < 2, 3'd5, j == 0, 32'h80, 32'h1, 8'h80, 8'h01);
            if (j < 4) begin
                total++;
                if ({v1, f1, r1} !== {w1v[j], w1f[j], 7'b0, w1f[j]}) begin
                    bad++;
                    $display("FAIL depth1 cyc=%0d got=%b%b want=%0d%0d",
                             j, v1, f1, w1v[j], w1f[j]);
                end
            end
            total++;
            if ({v2, f2, r2} !== {w4v[j], w4f[j], 7'b0, w4f[j]}) begin
                bad++;
                $display("FAIL depth4 cyc=%0d got=%b%b want=%0d%0d",
                         j, v2, f2, w4v[j], w4f[j]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [7:0]  sa, sb;
        for (int j = 0; j < 400; j++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            sa = 8'($urandom);
            sb = ($urandom_range(0, 3) == 0) ? sa : 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                a[31] = ~b[31];
                sa[7] = ~sb[7];
            end
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 70,
                 3'($urandom), 1'($urandom), a, b, sa, sb);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL random cyc=%0d k=%0d got=%h want=%h",
                             j, k, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) begin
                m_v[k][i] = 0;
                m_f[k][i] = 0;
            end
        test_reset();
        test_relations();
        test_signed();
        test_stall();
        test_flush();
        test_depth();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/set_cond_unit.md
# set_cond_unit

Pipelined, parametrised set-on-condition unit for the DLX execute path. It compares two WIDTH-bit operands under a selectable relation, signed or unsigned, and produces the DLX set-instruction result: 1 or 0 zero-extended to WIDTH bits. The result passes through a configurable number of register stages, with valid tracking, stall and flush. It sits between the operand-forwarding muxes and the EX/MEM result mux, replacing the fixed single-bit-to-32-bit extender.

## Interface
- WIDTH, 32, operand and result width in bits (legal values 2..64).
- STAGES, 2, pipeline depth in register stages (legal values 1..4).

- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- VALID_IN  in  1  operands and condition are valid this cycle.
- STALL  in  1  freeze the pipeline; nothing advances, inputs are not captured.
- FLUSH  in  1  discard all in-flight operations and the current input.
- A  in  WIDTH  operand A (rs1).
- B  in  WIDTH  operand B (rs2 or sign-extended immediate; extension is done upstream).
- COND  in  3  relation code: 000 EQ, 001 NE, 010 LT, 011 GT, 100 LE, 101 GE, 110 constant FALSE, 111 constant TRUE.
- SIGNED  in  1  1 = two's-complement compare, 0 = unsigned compare.
- RESULT  out  WIDTH  {WIDTH-1 zeros, FLAG}.
- FLAG  out  1  condition outcome.
- VALID_OUT  out  1  RESULT/FLAG carry a completed operation.

## Operation
- Stage 1 captures two flags from A, B and SIGNED, plus COND and VALID_IN:
  - eq = (A == B).
  - lt = signed or unsigned A < B, evaluated over the full WIDTH.
- The outcome is decoded from the flags:
  - EQ = eq; NE = !eq.
  - LT = lt; GT = !lt & !eq.
  - LE = lt | eq; GE = !lt.
  - FALSE = 0; TRUE = 1.
- Decode happens before the final stage register; its position is free, but only the final stage drives the outputs.
- Stages 2..STAGES are pure delay registers carrying the outcome and valid bit.
- Bubble rule: a stage holding valid=0 holds outcome=0. RESULT and FLAG are therefore 0 whenever VALID_OUT=0.
- RESULT[WIDTH-1:1] is constant 0. RESULT[0] equals FLAG.
- Priority per rising edge: RST > FLUSH > STALL > normal advance.
  - RST: every stage valid=0 and outcome=0.
  - FLUSH: same effect as RST for pipeline contents; the input presented that cycle is dropped, even with VALID_IN=1.
  - STALL (no FLUSH): every stage holds its value; the input is not captured. Upstream must hold A/B/COND/SIGNED/VALID_IN until a non-stall edge.
  - Normal: each stage takes the previous one; stage 1 takes the new input (bubble when VALID_IN=0).
- Nothing is held back in any COND/SIGNED combination; all 16 are legal.

## Timing
- Reset values: RESULT=0, FLAG=0, VALID_OUT=0. They appear after the first rising edge with RST=1 and hold while RST stays high.
- Latency: an input sampled at non-stall edge n appears on the outputs after edge n+STAGES-1 (STAGES=1: visible after the capture edge itself). Stalled edges add one cycle each.
- Throughput: one operation per non-stalled cycle; back-to-back VALID_IN is supported with no bubbles.
- Stall held k cycles: outputs are unchanged for those k cycles, and VALID_OUT stays as it was.
- FLUSH and STALL in the same cycle: the flush happens and the pipeline is empty afterwards.
- Reset mid-stream: all in-flight operations are lost and nothing is emitted for them afterwards.
- Unsigned boundary: 0xFFFFFFFF > 0 is true. Signed boundary: 0x80000000 < 0x7FFFFFFF is true.

## Test plan
All scenarios use WIDTH=32, STAGES=2 unless stated.

1. Reset: RST high 2 cycles with VALID_IN=1 -> RESULT=0, FLAG=0, VALID_OUT=0 throughout, and until the first valid input completes.
2. Relations: A=5, B=7, COND stepped 000..111 back-to-back -> FLAG sequence 0,1,1,0,1,0,0,1 with VALID_OUT continuous; each appears 1 cycle after its capture edge; RESULT=0x00000001 when FLAG=1.
3. Signed/unsigned: A=0xFFFFFFFF, B=0x00000001, COND=LT:
   - SIGNED=1 -> FLAG=1.
   - SIGNED=0 -> FLAG=0.
   - A=0x80000000, B=0x7FFFFFFF, GT, SIGNED=0 -> FLAG=1.
4. Stall: issue ops EQ(3,3) and NE(3,3), then assert STALL for 3 cycles after the first capture -> the first result (FLAG=1) holds on the outputs for 3 extra cycles; the second result (FLAG=0) follows on the first unstalled edge; nothing is lost or duplicated.
5. Flush: 2 valid TRUE ops in flight, then FLUSH=1 together with STALL=1 and VALID_IN=1 -> VALID_OUT=0 and RESULT=0 on the next cycles; the next op issued afterwards completes with normal latency.
6. Depth sweep: STAGES=1 and STAGES=4, WIDTH=8, A=0x80, B=0x01, GE:
   - SIGNED=1 -> FLAG=0.
   - SIGNED=0 -> FLAG=1.
   - Measured latency is 0 and 3 cycles after the capture edge respectively.
